// File: rtl/prim_chain_sequencer.sv
// Time-multiplexed primitive chain: one layer of IO_PAIRS pair primitives
// (odd ^= even, even = ~even) is applied to a held vector once per RUN cycle.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | applying one stage per cycle until the iteration count is exhausted
// DONE  | result held on out_data with out_valid high until the consumer takes it
module prim_chain_sequencer #(
  parameter int IO_PAIRS = 9,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*IO_PAIRS-1:0] in_data,
  input  logic [CNT_W-1:0]      in_iter,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*IO_PAIRS-1:0] out_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      stage_idx
);

  localparam int W = 2 * IO_PAIRS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     d_q, d_d, stage_out;
  logic [CNT_W-1:0] rem_q, rem_d, idx_q, idx_d;

  // one layer of primitives; the odd bit uses the even bit before inversion
  always_comb begin
    stage_out = d_q;
    for (int j = 0; j < IO_PAIRS; j++) begin
      stage_out[2*j+1] = d_q[2*j+1] ^ d_q[2*j];
      stage_out[2*j]   = ~d_q[2*j];
    end
  end

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          d_d     = in_data;
          rem_d   = in_iter;
          idx_d   = '0;
          state_d = (in_iter == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // abort wins over the final stage and freezes the partial result
        if (abort) begin
          state_d = IDLE;
        end else begin
          d_d   = stage_out;
          rem_d = rem_q - CNT_W'(1);
          idx_d = idx_q + CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  assign out_data  = d_q;
  assign stage_idx = idx_q;

endmodule

// File: tb/tb_prim_chain_sequencer.sv
// Scoreboard bench for prim_chain_sequencer: expected results are queued at
// accept time and compared when the output handshake is observed.
module tb_prim_chain_sequencer;

  localparam int P  = 9;
  localparam int W  = 2 * P;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_iter;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  logic [CW-1:0] stage_idx;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] stage;
  } exp_t;

  exp_t sb_q[$];

  prim_chain_sequencer #(.IO_PAIRS(P), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_iter   (in_iter),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .stage_idx (stage_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] v, input int n);
    logic [W-1:0] r;
    r = v;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < P; j++) begin
        r[2*j+1] = r[2*j+1] ^ r[2*j];
        r[2*j]   = ~r[2*j];
      end
    end
    return r;
  endfunction

  // handshake happens at the next rising edge; inputs are stable by now
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e.data));
        chk("sb_stage", 32'(stage_idx), 32'(e.stage));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] data, input logic [CW-1:0] iter);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_data  = data;
    in_iter  = iter;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_iter  = CW'($urandom);
  endtask

  task automatic wait_result(input int exp_edges, input string tag);
    int edges;
    int busy_cnt;
    edges    = 0;
    busy_cnt = 0;
    while (!out_valid && edges < 400) begin
      if (busy) busy_cnt++;
      tick();
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_edges));
    chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
  endtask

  task automatic full_req(input logic [W-1:0] data, input logic [CW-1:0] iter,
                          input logic [W-1:0] exp_data, input string tag);
    sb_q.push_back('{exp_data, iter});
    accept(data, iter);
    wait_result(int'(iter), tag);
    tick();
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic wait_stage(input logic [CW-1:0] target);
    int n;
    n = 0;
    while (stage_idx != target && n < 50) begin
      tick();
      n++;
    end
    chk("wait_stage_reached", 32'(stage_idx), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [W-1:0] rd;
    logic [CW-1:0] ri;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_iter   = '0;
    abort     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_stage_idx", 32'(stage_idx), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_out_data", 32'(out_data), 32'd0);

    full_req(18'h00000, 8'd1, 18'h15555, "iter1");
    full_req(18'h00000, 8'd2, 18'h2AAAA, "iter2");
    full_req(18'h3A5C3, 8'd4, 18'h3A5C3, "iter4_identity");
    full_req(18'h12345, 8'd0, 18'h12345, "iter0_pass");

    // abort after three stages have been applied
    accept(18'h0F0F0, 8'd5);
    wait_stage(8'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_stage_idx", 32'(stage_idx), 32'd3);
    chk("abort_out_data", 32'(out_data), 32'(model(18'h0F0F0, 3)));
    tick();
    tick();
    chk("abort_no_late_valid", 32'(out_valid), 32'd0);
    full_req(18'h0F0F0, 8'd5, model(18'h0F0F0, 5), "after_abort");

    // abort on the final RUN edge
    accept(18'h2468A, 8'd3);
    wait_stage(8'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_last_in_ready", 32'(in_ready), 32'd1);
    chk("abort_last_out_valid", 32'(out_valid), 32'd0);
    chk("abort_last_stage_idx", 32'(stage_idx), 32'd2);
    tick();
    chk("abort_last_no_valid", 32'(out_valid), 32'd0);

    // consumer stalls for 10 cycles; abort and a new request are ignored meanwhile
    out_ready = 1'b0;
    sb_q.push_back('{model(18'h1B2C3, 3), 8'd3});
    accept(18'h1B2C3, 8'd3);
    wait_result(3, "hold");
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 18'h3FFFF;
    in_iter  = 8'd0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_data", 32'(out_data), 32'(model(18'h1B2C3, 3)));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    abort     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("no_accept_on_handshake_in_ready", 32'(in_ready), 32'd1);
    chk("no_accept_on_handshake_out_valid", 32'(out_valid), 32'd0);
    chk("no_accept_on_handshake_stage", 32'(stage_idx), 32'd3);
    in_valid = 1'b0;

    // reset while a result is pending discards it
    out_ready = 1'b0;
    sb_q.push_back('{model(18'h15A5A, 2), 8'd2});
    accept(18'h15A5A, 8'd2);
    wait_result(2, "rst_done");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb_q.pop_back());
    chk("rst_done_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done_out_data", 32'(out_data), 32'd0);
    chk("rst_done_in_ready", 32'(in_ready), 32'd1);
    chk("rst_done_stage_idx", 32'(stage_idx), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("rst_done_stays_idle", 32'(out_valid), 32'd0);

    for (int i = 0; i < 6; i++) begin
      rd = W'($urandom);
      ri = CW'($urandom_range(0, 12));
      full_req(rd, ri, model(rd, int'(ri)), "rand");
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
